imem_fetch_arbiter: RTL

//  Shares the single-port, combinational-read instruction memory between NUM_CORES processor cores.

---
 rtl/imem_arb_pkg.sv | 20 ++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/imem_fetch_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory fetch arbiter: core-count limit,
// index width and a one-hot to binary index helper.
package imem_arb_pkg;

    localparam int MAX_CORES = 8;
    localparam int IDX_W     = 3;

    // Input must be one-hot or zero; zero yields index 0.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CORES; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo NUM_CORES. Returns the winner as one-hot and as an index.
module rr_priority_picker
    import imem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic [NUM_CORES-1:0] winner_oh,
    output logic [IDX_W-1:0]     winner_idx
);

    logic                 found;
    logic [MAX_CORES-1:0] oh_ext;

    always_comb begin
        winner_oh = '0;
        found     = 1'b0;
        // Outer loop walks priority distance from rr_ptr; first hit wins.
        for (int k = 0; k < NUM_CORES; k++) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!found && req[i] && (((int'(rr_ptr) + k) % NUM_CORES) == i)) begin
                    winner_oh[i] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
        oh_ext                  = '0;
        oh_ext[NUM_CORES-1:0]   = winner_oh;
        winner_idx              = onehot_to_idx(oh_ext);
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational-read instruction memory among cores,
// pipelined arbitrate/issue/response. Optional address merging under BROADCAST_MERGE_EN.
module imem_fetch_arbiter
    import imem_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_valid,
    output logic [DATA_W-1:0]           core_instr,
    output logic                        mem_read,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_data
);

    logic [NUM_CORES-1:0] issue_gnt_q, issue_gnt_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_read_q, mem_read_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] core_valid_q, core_valid_d;
    logic [DATA_W-1:0]    core_instr_q, core_instr_d;

    logic [NUM_CORES-1:0] eligible;
    logic [NUM_CORES-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic [ADDR_W-1:0]    win_addr;
    logic [NUM_CORES-1:0] gnt_vec;

    // A core in issue or response already has its one outstanding fetch.
    assign eligible = core_req & ~issue_gnt_q & ~core_valid_q;

    rr_priority_picker #(
        .NUM_CORES (NUM_CORES)
    ) u_picker (
        .req        (eligible),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (win_oh),
        .winner_idx (win_idx)
    );

    always_comb begin
        win_addr = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (win_oh[i]) begin
                win_addr = win_addr | core_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

`ifdef BROADCAST_MERGE_EN
    // Eligible cores fetching the winner's address ride along on the same read.
    always_comb begin
        gnt_vec = win_oh;
        for (int i = 0; i < NUM_CORES; i++) begin
            if ((|win_oh) && eligible[i] && (core_addr[i*ADDR_W +: ADDR_W] == win_addr)) begin
                gnt_vec[i] = 1'b1;
            end
        end
    end
`else
    assign gnt_vec = win_oh;
`endif

    always_comb begin
        issue_gnt_d = gnt_vec;
        mem_read_d  = |win_oh;
        mem_addr_d  = mem_addr_q;
        rr_ptr_d    = rr_ptr_q;
        if (|win_oh) begin
            mem_addr_d = win_addr;
            rr_ptr_d   = (win_idx == IDX_W'(NUM_CORES - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_comb begin
        core_valid_d = '0;
        core_instr_d = core_instr_q;
        if (mem_read_q) begin
            core_valid_d = issue_gnt_q;
            core_instr_d = mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_gnt_q  <= '0;
            mem_addr_q   <= '0;
            mem_read_q   <= 1'b0;
            rr_ptr_q     <= '0;
            core_valid_q <= '0;
            core_instr_q <= '0;
        end else begin
            issue_gnt_q  <= issue_gnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_read_q   <= mem_read_d;
            rr_ptr_q     <= rr_ptr_d;
            core_valid_q <= core_valid_d;
            core_instr_q <= core_instr_d;
        end
    end

    assign core_valid = core_valid_q;
    assign core_instr = core_instr_q;
    assign mem_read   = mem_read_q;
    assign mem_addr   = mem_addr_q;

endmodule
